// File: rtl/usb_ep_register_bank_if.sv
// Register-bank bus port: data-phase strobes from the AHB decoder, read data and stall back.
interface usb_ep_register_bank_if #(
  parameter int EPW = 1
);
  logic [EPW-1:0] ep_sel;
  logic [2:0]     reg_sel;
  logic           wr_en;
  logic           rd_en;
  logic [2:0]     nbytes;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic           hold;

  modport master (
    output ep_sel, reg_sel, wr_en, rd_en, nbytes, wdata,
    input  rdata, hold
  );

  modport slave (
    input  ep_sel, reg_sel, wr_en, rd_en, nbytes, wdata,
    output rdata, hold
  );
endinterface

// File: rtl/usb_ep_register_bank.sv
// Per-endpoint USB status/error/TX-control/flush registers with a byte-serialising
// DATA window into the shared endpoint FIFO interface.
module usb_ep_register_bank #(
  parameter int NUM_EP    = 2,
  parameter int BUF_DEPTH = 64,
  parameter int OCC_W     = 7,
  parameter int EPW       = $clog2(NUM_EP)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  usb_ep_register_bank_if.slave   bus,
  input  logic [3*NUM_EP-1:0]     rx_packet,
  input  logic [NUM_EP-1:0]       rx_data_ready,
  input  logic [NUM_EP-1:0]       rx_transfer_active,
  input  logic [NUM_EP-1:0]       rx_error,
  input  logic [NUM_EP-1:0]       tx_transfer_active,
  input  logic [NUM_EP-1:0]       tx_error,
  input  logic [OCC_W*NUM_EP-1:0] buffer_occupancy,
  input  logic [7:0]              rx_data,
  output logic [NUM_EP-1:0]       get_rx_data,
  output logic [NUM_EP-1:0]       store_tx_data,
  output logic [NUM_EP-1:0]       clear,
  output logic [NUM_EP-1:0]       tx_start,
  output logic [NUM_EP-1:0]       irq,
  output logic [7:0]              tx_data,
  output logic [2*NUM_EP-1:0]     tx_packet,
  output logic                    d_mode
);

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_ERROR   = 3'd2;
  localparam logic [2:0] REG_OCCUP   = 3'd3;
  localparam logic [2:0] REG_TX_CTRL = 3'd4;
  localparam logic [2:0] REG_FLUSH   = 3'd5;
  localparam logic [2:0] REG_IRQ_EN  = 3'd6;

  localparam logic [2:0] PID_OUT   = 3'd0;
  localparam logic [2:0] PID_IN    = 3'd1;
  localparam logic [2:0] PID_DATA0 = 3'd2;
  localparam logic [2:0] PID_DATA1 = 3'd3;
  localparam logic [2:0] PID_ACK   = 3'd4;
  localparam logic [2:0] PID_NAK   = 3'd5;

  localparam logic [2:0] TXC_NONE  = 3'd0;
  localparam logic [2:0] TXC_DATA  = 3'd1;
  localparam logic [2:0] TXC_ACK   = 3'd2;
  localparam logic [2:0] TXC_NAK   = 3'd3;
  localparam logic [2:0] TXC_STALL = 3'd4;

  localparam logic [OCC_W:0] DEPTH_L = (OCC_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic txc_valid(input logic [7:0] v);
    case (v)
      8'd1, 8'd2, 8'd3, 8'd4: txc_valid = 1'b1;
      default:                txc_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] txc_map(input logic [2:0] c);
    case (c)
      TXC_DATA:  txc_map = 2'd2;
      TXC_ACK:   txc_map = 2'd0;
      TXC_NAK:   txc_map = 2'd1;
      TXC_STALL: txc_map = 2'd3;
      default:   txc_map = 2'd0;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [EPW-1:0]   ep_r;
  logic             dir_rd_r;
  logic [2:0]       n_r, avail_r, idx_r;
  logic [31:0]      data_r;

  logic [4:0]       status_r [NUM_EP];
  logic [4:0]       status_s [NUM_EP];
  logic [3:0]       err_r    [NUM_EP];
  logic [3:0]       err_s    [NUM_EP];
  logic [4:0]       irq_en_r [NUM_EP];
  logic [4:0]       irq_en_s [NUM_EP];
  logic [2:0]       tx_ctrl_r [NUM_EP];
  logic [2:0]       tx_ctrl_s [NUM_EP];
  logic [1:0]       tx_packet_r [NUM_EP];
  logic [1:0]       tx_packet_s [NUM_EP];
  logic [NUM_EP-1:0] tx_start_r, tx_start_s, clear_r, clear_s;
  logic [NUM_EP-1:0] rx_act_q_r, tx_act_q_r;

  logic [OCC_W-1:0] occ_s [NUM_EP];
  logic [2:0]       pid_s [NUM_EP];
  logic [NUM_EP-1:0] sel_e_s, st_clr_s, err_clr_s, txc_wr_s, irqen_wr_s, start_ok_s;
  logic [OCC_W-1:0] sel_occ_s;
  logic [OCC_W:0]   occ_ext_s, n_ext_s, space_s;
  logic             hold_s, acc_wr_s, acc_rd_s, start_s, underrun_s, overflow_s, byte_act_s;
  logic [2:0]       n_s, avail_s;
  logic [4:0]       sel_status_s, sel_irqen_s;
  logic [3:0]       sel_err_s;
  logic [2:0]       sel_txc_s;
  logic             sel_flush_s, sel_rxa_s, sel_txa_s;
  logic [31:0]      word_s, rdata_s;

  // Bus strobe qualification and access-size decode
  always_comb begin
    hold_s   = (state_r != S_IDLE);
    acc_wr_s = bus.wr_en & ~hold_s;
    acc_rd_s = bus.rd_en & ~hold_s;
    start_s  = (acc_wr_s | acc_rd_s) & (bus.reg_sel == REG_DATA);
    case (bus.nbytes)
      3'd1:    n_s = 3'd1;
      3'd2:    n_s = 3'd2;
      default: n_s = 3'd4;
    endcase
  end

  // Per-endpoint input slicing and selected-endpoint occupancy
  always_comb begin
    sel_occ_s = '0;
    for (int e = 0; e < NUM_EP; e++) begin
      occ_s[e]   = buffer_occupancy[OCC_W*e +: OCC_W];
      pid_s[e]   = rx_packet[3*e +: 3];
      sel_e_s[e] = (bus.ep_sel == EPW'(e));
      sel_occ_s  = sel_occ_s | (occ_s[e] & {OCC_W{sel_e_s[e]}});
    end
  end

  // Bytes actually moved: short reads stop at occupancy, long writes stop at free space
  always_comb begin
    occ_ext_s  = {1'b0, sel_occ_s};
    n_ext_s    = (OCC_W+1)'(n_s);
    underrun_s = (occ_ext_s < n_ext_s);
    overflow_s = ((occ_ext_s + n_ext_s) > DEPTH_L);
    if (occ_ext_s >= DEPTH_L) begin
      space_s = '0;
    end else begin
      space_s = DEPTH_L - occ_ext_s;
    end
    if (acc_rd_s) begin
      if (underrun_s) avail_s = 3'(sel_occ_s);
      else            avail_s = n_s;
    end else begin
      if (overflow_s) avail_s = 3'(space_s);
      else            avail_s = n_s;
    end
  end

  // DATA window state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // DATA window next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) state_s = S_XFER;
        else         state_s = S_IDLE;
      end
      S_XFER: begin
        if (idx_r == (n_r - 3'd1)) state_s = S_DONE;
        else                       state_s = S_XFER;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // DATA window access latch, byte index and read-byte assembly
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ep_r     <= '0;
      dir_rd_r <= 1'b0;
      n_r      <= 3'd0;
      avail_r  <= 3'd0;
      idx_r    <= 3'd0;
      data_r   <= 32'h0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            ep_r     <= bus.ep_sel;
            dir_rd_r <= acc_rd_s;
            n_r      <= n_s;
            avail_r  <= avail_s;
            idx_r    <= 3'd0;
            data_r   <= acc_rd_s ? 32'h0 : bus.wdata;
          end
        end
        S_XFER: begin
          idx_r <= idx_r + 3'd1;
          if (dir_rd_r && (idx_r < avail_r)) data_r[{idx_r[1:0], 3'b000} +: 8] <= rx_data;
        end
        default: idx_r <= 3'd0;
      endcase
    end
  end

  // FIFO strobes for the latched endpoint while a byte is in range
  always_comb begin
    byte_act_s = (state_r == S_XFER) & (idx_r < avail_r);
    for (int e = 0; e < NUM_EP; e++) begin
      get_rx_data[e]   = byte_act_s &  dir_rd_r & (ep_r == EPW'(e));
      store_tx_data[e] = byte_act_s & ~dir_rd_r & (ep_r == EPW'(e));
    end
    if (byte_act_s & ~dir_rd_r) tx_data = data_r[{idx_r[1:0], 3'b000} +: 8];
    else                        tx_data = 8'h00;
  end

  // Per-endpoint register next state; where set and clear collide, set wins
  always_comb begin
    for (int e = 0; e < NUM_EP; e++) begin
      st_clr_s[e]   = acc_rd_s & (bus.reg_sel == REG_STATUS)  & sel_e_s[e];
      err_clr_s[e]  = acc_rd_s & (bus.reg_sel == REG_ERROR)   & sel_e_s[e];
      txc_wr_s[e]   = acc_wr_s & (bus.reg_sel == REG_TX_CTRL) & sel_e_s[e];
      irqen_wr_s[e] = acc_wr_s & (bus.reg_sel == REG_IRQ_EN)  & sel_e_s[e];

      status_s[e][0] = (rx_data_ready[e] & ((pid_s[e] == PID_DATA0) | (pid_s[e] == PID_DATA1)))
                     | (status_r[e][0] & (occ_s[e] != '0));
      status_s[e][1] = (rx_data_ready[e] & (pid_s[e] == PID_IN))  | (status_r[e][1] & ~st_clr_s[e]);
      status_s[e][2] = (rx_data_ready[e] & (pid_s[e] == PID_OUT)) | (status_r[e][2] & ~st_clr_s[e]);
      status_s[e][3] = (rx_data_ready[e] & (pid_s[e] == PID_ACK)) | (status_r[e][3] & ~st_clr_s[e]);
      status_s[e][4] = (rx_data_ready[e] & (pid_s[e] == PID_NAK)) | (status_r[e][4] & ~st_clr_s[e]);

      err_s[e][0] = rx_error[e] | (err_r[e][0] & ~(rx_transfer_active[e] & ~rx_act_q_r[e]));
      err_s[e][1] = (start_s & acc_rd_s & sel_e_s[e] & underrun_s) | (err_r[e][1] & ~err_clr_s[e]);
      err_s[e][2] = tx_error[e] | (err_r[e][2] & ~(tx_transfer_active[e] & ~tx_act_q_r[e]));
      err_s[e][3] = (start_s & acc_wr_s & sel_e_s[e] & overflow_s) | (err_r[e][3] & ~err_clr_s[e]);

      if (irqen_wr_s[e]) irq_en_s[e] = bus.wdata[4:0];
      else               irq_en_s[e] = irq_en_r[e];

      clear_s[e] = acc_wr_s & (bus.reg_sel == REG_FLUSH) & sel_e_s[e] & (bus.wdata != 32'h0);

      // DATA requests wait for something in the FIFO before launching
      start_ok_s[e] = (tx_ctrl_r[e] != TXC_NONE) & ~tx_transfer_active[e]
                    & ((tx_ctrl_r[e] != TXC_DATA) | (occ_s[e] != '0));
      tx_start_s[e] = start_ok_s[e];
      if (start_ok_s[e]) tx_packet_s[e] = txc_map(tx_ctrl_r[e]);
      else               tx_packet_s[e] = tx_packet_r[e];

      if (txc_wr_s[e]) begin
        if (txc_valid(bus.wdata[7:0])) tx_ctrl_s[e] = bus.wdata[2:0];
        else                           tx_ctrl_s[e] = TXC_NONE;
      end else if (start_ok_s[e]) begin
        tx_ctrl_s[e] = TXC_NONE;
      end else begin
        tx_ctrl_s[e] = tx_ctrl_r[e];
      end
    end
  end

  // Per-endpoint register bank
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int e = 0; e < NUM_EP; e++) begin
        status_r[e]    <= 5'h0;
        err_r[e]       <= 4'h0;
        irq_en_r[e]    <= 5'h0;
        tx_ctrl_r[e]   <= TXC_NONE;
        tx_packet_r[e] <= 2'd0;
      end
      tx_start_r <= '0;
      clear_r    <= '0;
      rx_act_q_r <= '0;
      tx_act_q_r <= '0;
    end else begin
      for (int e = 0; e < NUM_EP; e++) begin
        status_r[e]    <= status_s[e];
        err_r[e]       <= err_s[e];
        irq_en_r[e]    <= irq_en_s[e];
        tx_ctrl_r[e]   <= tx_ctrl_s[e];
        tx_packet_r[e] <= tx_packet_s[e];
      end
      tx_start_r <= tx_start_s;
      clear_r    <= clear_s;
      rx_act_q_r <= rx_transfer_active;
      tx_act_q_r <= tx_transfer_active;
    end
  end

  // Register read mux for the addressed endpoint; DONE presents the assembled DATA word
  always_comb begin
    sel_status_s = 5'h0;
    sel_err_s    = 4'h0;
    sel_txc_s    = 3'h0;
    sel_irqen_s  = 5'h0;
    sel_flush_s  = 1'b0;
    sel_rxa_s    = 1'b0;
    sel_txa_s    = 1'b0;
    for (int e = 0; e < NUM_EP; e++) begin
      sel_status_s |= status_r[e]  & {5{sel_e_s[e]}};
      sel_err_s    |= err_r[e]     & {4{sel_e_s[e]}};
      sel_txc_s    |= tx_ctrl_r[e] & {3{sel_e_s[e]}};
      sel_irqen_s  |= irq_en_r[e]  & {5{sel_e_s[e]}};
      sel_flush_s  |= clear_r[e]            & sel_e_s[e];
      sel_rxa_s    |= rx_transfer_active[e] & sel_e_s[e];
      sel_txa_s    |= tx_transfer_active[e] & sel_e_s[e];
    end
    case (bus.reg_sel)
      REG_STATUS:  word_s = {16'h0, 6'h0, sel_txa_s, sel_rxa_s, 3'h0, sel_status_s};
      REG_ERROR:   word_s = {16'h0, 6'h0, sel_err_s[3], sel_err_s[2], 6'h0, sel_err_s[1], sel_err_s[0]};
      REG_OCCUP:   word_s = 32'(sel_occ_s);
      REG_TX_CTRL: word_s = 32'(sel_txc_s);
      REG_FLUSH:   word_s = 32'(sel_flush_s);
      REG_IRQ_EN:  word_s = 32'(sel_irqen_s);
      default:     word_s = 32'h0;
    endcase
    if (state_r == S_DONE) begin
      if (dir_rd_r) rdata_s = data_r;
      else          rdata_s = 32'h0;
    end else if (acc_rd_s) begin
      rdata_s = word_s;
    end else begin
      rdata_s = 32'h0;
    end
  end

  // Interrupt and TX packet output mapping
  always_comb begin
    for (int e = 0; e < NUM_EP; e++) begin
      irq[e]            = |(status_r[e] & irq_en_r[e]);
      tx_packet[2*e +: 2] = tx_packet_r[e];
    end
  end

  assign bus.hold  = hold_s;
  assign bus.rdata = rdata_s;
  assign clear     = clear_r;
  assign tx_start  = tx_start_r;
  assign d_mode    = |tx_transfer_active;

endmodule

// File: tb/tb_usb_ep_register_bank.sv
// Directed self-checking bench for usb_ep_register_bank (NUM_EP=2, BUF_DEPTH=64).
module tb_usb_ep_register_bank;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [5:0]  rx_packet = 6'h0;
  logic [1:0]  rx_data_ready = 2'b00, rx_transfer_active = 2'b00, rx_error = 2'b00;
  logic [1:0]  tx_transfer_active = 2'b00, tx_error = 2'b00;
  logic [13:0] buffer_occupancy = 14'h0;
  logic [7:0]  rx_data = 8'h00;
  logic [1:0]  get_rx_data, store_tx_data, clear, tx_start, irq;
  logic [7:0]  tx_data;
  logic [3:0]  tx_packet;
  logic        d_mode;
  int          n_cmp = 0;
  int          n_err = 0;

  usb_ep_register_bank_if #(.EPW(1)) bus ();

  usb_ep_register_bank dut (
    .clk(clk), .n_rst(n_rst), .bus(bus),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
    .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .buffer_occupancy(buffer_occupancy), .rx_data(rx_data),
    .get_rx_data(get_rx_data), .store_tx_data(store_tx_data), .clear(clear),
    .tx_start(tx_start), .irq(irq), .tx_data(tx_data), .tx_packet(tx_packet),
    .d_mode(d_mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input logic wr, input logic rd, input logic ep,
                           input logic [2:0] rs, input logic [2:0] nb, input logic [31:0] wd);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.ep_sel  = ep;
    bus.reg_sel = rs;
    bus.nbytes  = nb;
    bus.wdata   = wd;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.hold !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %0h want 0", bus.hold); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if ({tx_packet, irq, tx_data} !== 14'h0) begin n_err++;
      $display("FAIL reset_outs: got pkt=%h irq=%h txd=%h want 0", tx_packet, irq, tx_data); end
    n_cmp++; if ({get_rx_data, store_tx_data, clear, tx_start} !== 8'h0) begin n_err++;
      $display("FAIL reset_strobes: got %h want 0", {get_rx_data, store_tx_data, clear, tx_start}); end
    @(posedge clk); #1 n_rst = 1'b1;
    tick();
    // start a 4-byte write on ep0 and reset it mid-transfer
    bus_drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 32'h01020304);
    tick();
    bus.wr_en = 1'b0;
    n_cmp++; if (store_tx_data !== 2'b01) begin n_err++; $display("FAIL midx_store: got %b want 01", store_tx_data); end
    tick();
    #2 n_rst = 1'b0;
    #1;
    n_cmp++; if ({bus.hold, store_tx_data} !== 3'b000) begin n_err++;
      $display("FAIL midx_async: got hold=%b store=%b want 0", bus.hold, store_tx_data); end
    @(posedge clk); #1 n_rst = 1'b1;
    tick(); tick();
    n_cmp++; if ({bus.hold, store_tx_data} !== 3'b000) begin n_err++;
      $display("FAIL midx_after: got hold=%b store=%b want 0", bus.hold, store_tx_data); end
  endtask

  task automatic test_write4();
    logic [7:0] exp_b [4];
    int hold_cnt;
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    hold_cnt = 0;
    bus_drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd4, 32'hA1B2C3D4);
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({store_tx_data, tx_data} !== {2'b10, exp_b[i]}) begin n_err++;
        $display("FAIL wr4_byte%0d: got store=%b data=%h want 10/%h", i, store_tx_data, tx_data, exp_b[i]); end
      if (bus.hold) hold_cnt++;
      tick();
    end
    n_cmp++; if (store_tx_data !== 2'b00) begin n_err++; $display("FAIL wr4_done_store: got %b want 00", store_tx_data); end
    if (bus.hold) hold_cnt++;
    tick();
    if (bus.hold) hold_cnt++;
    n_cmp++; if (hold_cnt !== 5) begin n_err++; $display("FAIL wr4_hold_cycles: got %0d want 5", hold_cnt); end
  endtask

  task automatic test_read_underrun();
    buffer_occupancy = {7'd0, 7'd1};
    rx_data = 8'h5A;
    bus_drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 32'h0);
    tick();
    bus.rd_en = 1'b0;
    n_cmp++; if (get_rx_data !== 2'b01) begin n_err++; $display("FAIL rd_get0: got %b want 01", get_rx_data); end
    tick();
    n_cmp++; if (get_rx_data !== 2'b00) begin n_err++; $display("FAIL rd_get1: got %b want 00", get_rx_data); end
    tick();
    n_cmp++; if ({bus.hold, bus.rdata} !== {1'b1, 32'h0000005A}) begin n_err++;
      $display("FAIL rd_done_rdata: got hold=%b rdata=%h want 1/0000005a", bus.hold, bus.rdata); end
    tick();
    bus_drive(1'b0, 1'b1, 1'b0, 3'd2, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h2) begin n_err++; $display("FAIL rd_underrun_err: got %h want 00000002", bus.rdata); end
    tick();
    #1;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rd_err_cleared: got %h want 0", bus.rdata); end
    bus.rd_en = 1'b0;
    buffer_occupancy = 14'h0;
    tick();
  endtask

  task automatic test_sticky_irq();
    bus_drive(1'b1, 1'b0, 1'b0, 3'd6, 3'd4, 32'h2);
    tick();
    bus.wr_en = 1'b0;
    rx_packet = 6'b000_001;
    rx_data_ready = 2'b01;
    tick();
    rx_data_ready = 2'b00;
    n_cmp++; if (irq !== 2'b01) begin n_err++; $display("FAIL irq_set: got %b want 01", irq); end
    bus_drive(1'b0, 1'b1, 1'b0, 3'd1, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h0002) begin n_err++; $display("FAIL status_read: got %h want 00000002", bus.rdata); end
    tick();
    bus.rd_en = 1'b0;
    n_cmp++; if (irq !== 2'b00) begin n_err++; $display("FAIL irq_cleared: got %b want 00", irq); end
  endtask

  task automatic test_tx_ctrl();
    bus_drive(1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 32'h1);
    tick();
    bus_drive(1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h1) begin n_err++; $display("FAIL txc_pending: got %h want 1", bus.rdata); end
    tick();
    bus.rd_en = 1'b0;
    n_cmp++; if (tx_start !== 2'b00) begin n_err++; $display("FAIL txc_holdoff: got %b want 00", tx_start); end
    buffer_occupancy = {7'd0, 7'd8};
    tick();
    n_cmp++; if ({tx_start, tx_packet[1:0]} !== {2'b01, 2'd2}) begin n_err++;
      $display("FAIL txc_start: got start=%b pkt=%0d want 01/2", tx_start, tx_packet[1:0]); end
    bus_drive(1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL txc_selfclr: got %h want 0", bus.rdata); end
    tick();
    bus.rd_en = 1'b0;
    n_cmp++; if ({tx_start, tx_packet[1:0]} !== {2'b00, 2'd2}) begin n_err++;
      $display("FAIL txc_pulse_end: got start=%b pkt=%0d want 00/2", tx_start, tx_packet[1:0]); end
    buffer_occupancy = 14'h0;
  endtask

  task automatic test_flush_invalid();
    bus_drive(1'b1, 1'b0, 1'b1, 3'd5, 3'd4, 32'hFF);
    tick();
    bus.wr_en = 1'b0;
    n_cmp++; if (clear !== 2'b10) begin n_err++; $display("FAIL flush_pulse: got %b want 10", clear); end
    tick();
    n_cmp++; if (clear !== 2'b00) begin n_err++; $display("FAIL flush_end: got %b want 00", clear); end
    bus_drive(1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 32'h7);
    tick();
    bus_drive(1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL txc_invalid: got %h want 0", bus.rdata); end
    tick();
    bus.rd_en = 1'b0;
    n_cmp++; if (tx_start !== 2'b00) begin n_err++; $display("FAIL txc_invalid_start: got %b want 00", tx_start); end
    tx_transfer_active = 2'b10;
    #1;
    n_cmp++; if (d_mode !== 1'b1) begin n_err++; $display("FAIL d_mode: got %b want 1", d_mode); end
    tx_transfer_active = 2'b00;
    tick();
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    buffer_occupancy = {7'd62, 7'd0};
    bus_drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd4, 32'h11223344);
    tick();
    for (int i = 0; i < 6; i++) begin
      // a write to IRQ_EN while stalled must be dropped
      if (i == 0) bus_drive(1'b1, 1'b0, 1'b1, 3'd6, 3'd4, 32'h1F);
      else        bus.wr_en = 1'b0;
      if (store_tx_data[1]) pulses++;
      tick();
    end
    n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL ovf_pulses: got %0d want 2", pulses); end
    bus_drive(1'b0, 1'b1, 1'b1, 3'd2, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h200) begin n_err++; $display("FAIL ovf_err: got %h want 00000200", bus.rdata); end
    tick();
    bus_drive(1'b0, 1'b1, 1'b1, 3'd6, 3'd4, 32'h0);
    #1;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL hold_ignored_wr: got %h want 0", bus.rdata); end
    tick();
    bus.rd_en = 1'b0;
    buffer_occupancy = 14'h0;
  endtask

  initial begin
    bus_drive(1'b0, 1'b0, 1'b0, 3'd7, 3'd4, 32'h0);
    test_reset();
    test_write4();
    test_read_underrun();
    test_sticky_irq();
    test_tx_ctrl();
    test_flush_invalid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
